// File: rtl/expu_accumulator.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | expu_accumulator: softmax denominator accumulator behind the exp unit.    |
// | Optional macro SFM_ACC_SATURATION_EN selects saturating accumulation.     |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+

// Minimal subset of fpnew_pkg so the block elaborates on its own.
package fpnew_pkg;
   typedef enum logic [2:0] {FP32, FP64, FP16, FP8, FP16ALT, FP8ALT} fp_format_e;

   function automatic int unsigned exp_bits(input fp_format_e fmt);
      case (fmt)
         FP32:    return 8;
         FP64:    return 11;
         FP16:    return 5;
         FP8:     return 5;
         FP16ALT: return 8;
         default: return 4;
      endcase
   endfunction

   function automatic int unsigned man_bits(input fp_format_e fmt);
      case (fmt)
         FP32:    return 23;
         FP64:    return 52;
         FP16:    return 10;
         FP8:     return 2;
         FP16ALT: return 7;
         default: return 3;
      endcase
   endfunction

   function automatic int unsigned fp_width(input fp_format_e fmt);
      return 1 + exp_bits(fmt) + man_bits(fmt);
   endfunction
endpackage

module expu_accumulator #(
   parameter fpnew_pkg::fp_format_e FPFORMAT = fpnew_pkg::FP16ALT,
   parameter int unsigned N_ROWS   = 1,
   parameter int unsigned ACC_FRAC = 16,
   parameter int unsigned ACC_INT  = 16,
   localparam int unsigned WIDTH         = fpnew_pkg::fp_width(FPFORMAT),
   localparam int unsigned MANTISSA_BITS = fpnew_pkg::man_bits(FPFORMAT),
   localparam int unsigned EXPONENT_BITS = fpnew_pkg::exp_bits(FPFORMAT),
   localparam int          BIAS          = (2 ** (EXPONENT_BITS - 1)) - 1,
   localparam int unsigned ACC_W         = ACC_INT + ACC_FRAC
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic                         clear_i,
   input  logic                         enable_i,
   input  logic                         valid_i,
   output logic                         ready_o,
   input  logic [N_ROWS-1:0]            strb_i,
   input  logic [N_ROWS-1:0][WIDTH-1:0] op_i,
   input  logic                         last_i,
   output logic [ACC_W-1:0]             sum_o,
   output logic                         sum_valid_o,
   input  logic                         sum_ready_i,
   output logic                         overflow_o,
   output logic                         busy_o
);

   localparam int unsigned SIG_W  = MANTISSA_BITS + 1;
   localparam int unsigned LSUM_W = ACC_W + $clog2(N_ROWS);
   localparam int unsigned UPD_W  = LSUM_W + 1;

   typedef enum logic [0:0] {
      ST_ACC  = 1'b0,
      ST_HOLD = 1'b1
   } state_e;

   state_e             state_q, state_d;
   logic [ACC_W-1:0]   acc_q, acc_d;
   logic               ovf_q, ovf_d;
   logic               seen_q, seen_d;

   logic [LSUM_W-1:0]  lane_sum;
   logic               lane_ovf;
   logic [UPD_W-1:0]   acc_upd;
   logic               carry_ovf;
   logic               beat_acc;
   logic               res_acc;

   // Returns {overflow, value}; value is the lane in unsigned Q(ACC_INT).(ACC_FRAC).
   function automatic logic [ACC_W:0] conv_lane(input logic [WIDTH-1:0] op);
      logic                     sgn;
      logic [EXPONENT_BITS-1:0] e;
      logic [SIG_W-1:0]         sig;
      logic [ACC_W+SIG_W-1:0]   wide;
      logic [ACC_W-1:0]         val;
      logic                     ovf;
      int                       sh;
      sgn  = op[WIDTH-1];
      e    = op[WIDTH-2 -: EXPONENT_BITS];
      sig  = {1'b1, op[MANTISSA_BITS-1:0]};
      wide = '0;
      val  = '0;
      ovf  = 1'b0;
      sh   = int'(e) - BIAS - int'(MANTISSA_BITS) + int'(ACC_FRAC);
      if (!sgn && (e != '0)) begin
         if (&e) begin
            ovf = 1'b1;
         end else if (sh >= 0) begin
            // The hidden bit is always set, so a shift past the top always loses it.
            if (sh >= int'(ACC_W)) begin
               ovf = 1'b1;
            end else begin
               wide = {{ACC_W{1'b0}}, sig} << sh;
               val  = wide[ACC_W-1:0];
               ovf  = |wide[ACC_W+SIG_W-1:ACC_W];
            end
         end else if ((-sh) < int'(ACC_W)) begin
            val = ACC_W'(sig >> (-sh));
         end
      end
      return {ovf, val};
   endfunction

   always_comb begin
      logic [ACC_W:0] conv;
      conv     = '0;
      lane_sum = '0;
      lane_ovf = 1'b0;
      for (int r = 0; r < int'(N_ROWS); r++) begin
         if (strb_i[r]) begin
            conv     = conv_lane(op_i[r]);
            lane_sum = lane_sum + LSUM_W'(conv[ACC_W-1:0]);
            lane_ovf = lane_ovf | conv[ACC_W];
         end
      end
   end

   assign acc_upd   = UPD_W'(acc_q) + UPD_W'(lane_sum);
   assign carry_ovf = |acc_upd[UPD_W-1:ACC_W];
   assign beat_acc  = (state_q == ST_ACC) & enable_i & valid_i;
   assign res_acc   = (state_q == ST_HOLD) & enable_i & sum_ready_i;

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      ovf_d   = ovf_q;
      seen_d  = seen_q;
      if (clear_i) begin
         state_d = ST_ACC;
         acc_d   = '0;
         ovf_d   = 1'b0;
         seen_d  = 1'b0;
      end else if (beat_acc) begin
         ovf_d  = ovf_q | lane_ovf | carry_ovf;
`ifdef SFM_ACC_SATURATION_EN
         acc_d  = (ovf_q | lane_ovf | carry_ovf) ? {ACC_W{1'b1}} : acc_upd[ACC_W-1:0];
`else
         acc_d  = acc_upd[ACC_W-1:0];
`endif
         seen_d = 1'b1;
         if (last_i) begin
            state_d = ST_HOLD;
         end
      end else if (res_acc) begin
         state_d = ST_ACC;
         acc_d   = '0;
         ovf_d   = 1'b0;
         seen_d  = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ST_ACC;
         acc_q   <= '0;
         ovf_q   <= 1'b0;
         seen_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         ovf_q   <= ovf_d;
         seen_q  <= seen_d;
      end
   end

   assign ready_o     = enable_i & (state_q == ST_ACC);
   assign sum_valid_o = (state_q == ST_HOLD);
   assign sum_o       = acc_q;
   assign overflow_o  = ovf_q;
   assign busy_o      = (acc_q != '0) | (state_q == ST_HOLD) | seen_q;

endmodule

`default_nettype wire

// File: doc/expu_accumulator.md
# expu_accumulator

Softmax denominator accumulator sitting directly downstream of the exponential unit. Consumes strobed multi-lane exponential results over a valid/ready handshake and converts each active non-negative lane to unsigned fixed point. Sums all lanes of a beat and accumulates across beats until a beat flagged `last_i`. Presents the finished sum to the normalisation stage over a second valid/ready handshake, then clears itself for the next vector.

## Interface
- `FPFORMAT`, `fpnew_pkg::FP16ALT`: input float format; `WIDTH`, `MANTISSA_BITS`, `EXPONENT_BITS`, `BIAS` derived from it via `fpnew_pkg`.
- `N_ROWS`, 1: lanes per beat.
- `ACC_FRAC`, 16: fraction bits of the accumulator.
- `ACC_INT`, 16: integer bits of the accumulator; `ACC_W = ACC_INT + ACC_FRAC`.

Ports:
- `clk_i` in 1: clock.
- `rst_ni` in 1: asynchronous active-low reset.
- `clear_i` in 1: synchronous clear, same effect as reset.
- `enable_i` in 1: global enable; when 0, no state changes and `ready_o` = 0.
- `valid_i` in 1: input beat valid.
- `ready_o` out 1: input beat accepted when `valid_i & ready_o`.
- `strb_i` in `N_ROWS`: per-lane active mask.
- `op_i` in `N_ROWS`×`WIDTH`: exponential results.
- `last_i` in 1: beat closes the current vector.
- `sum_o` out `ACC_W`: accumulated sum, unsigned Q`ACC_INT`.`ACC_FRAC`.
- `sum_valid_o` out 1: `sum_o` holds a finished sum.
- `sum_ready_i` in 1: downstream accepts the sum.
- `overflow_o` out 1: sticky overflow for the current vector.
- `busy_o` out 1: accumulator non-empty or result pending.

## Operation
- FSM states:
  - ACC (reset state): `ready_o = enable_i`.
  - HOLD: `ready_o` = 0; `sum_valid_o` = 1.
- Transitions:
  - ACC→HOLD on an accepted beat with `last_i` = 1.
  - HOLD→ACC on `sum_valid_o & sum_ready_i & enable_i`.
- Lane conversion is combinational and applies to lanes with `strb_i` bit set; masked lanes contribute 0.
  - Sign = 1, or exponent = 0 (zero/subnormal): contributes 0.
  - Exponent all-ones (inf/NaN): contributes 0 and sets overflow.
  - Otherwise value = `{1, mantissa}` shifted by `e - BIAS - MANTISSA_BITS + ACC_FRAC`.
  - Right shifts truncate; shifts of `ACC_W` or more give 0.
  - A left shift that drops a set bit sets overflow.
- Lane sum uses `ACC_W + $clog2(N_ROWS)` bits. The accumulator update uses one extra bit. Any carry beyond `ACC_W` sets overflow.
- On an accepted beat, the accumulator takes accumulator + lane sum. This includes the `last_i` beat.
- On an accepted result handshake, the accumulator and `overflow_o` clear to 0.
- `overflow_o` is sticky from the cycle after the offending beat until the result handshake or a clear.
- `busy_o` = (accumulator ≠ 0) | (state == HOLD) | beat-seen-since-clear flag.
- `sum_o` always shows the accumulator value.
- An accepted beat with no active lanes still counts. With `last_i` = 1 it still closes the vector.

## Timing
- Reset/clear: state ACC, accumulator 0, `sum_valid_o` 0, `overflow_o` 0, `busy_o` 0, `ready_o` = `enable_i`.
- Accumulate latency: beat accepted in cycle t; `sum_o` reflects it in cycle t+1.
- Result latency: last beat accepted in cycle t; `sum_valid_o` = 1 in cycle t+1.
- Throughput: 1 beat/cycle in ACC. One bubble per vector, since `ready_o` = 0 in the cycle `sum_valid_o` is first asserted and through HOLD.
- HOLD: `sum_o` and `overflow_o` stay stable until the handshake. `ready_o` returns to 1 the cycle after the handshake.
- `enable_i` = 0 freezes all state, including during HOLD; handshakes on either side are ignored.
- `clear_i` takes priority over every other event in the same cycle.

## Configuration
- `SFM_ACC_SATURATION_EN` defined: when overflow is set, the accumulator saturates to all-ones and holds there for the rest of the vector.
- `SFM_ACC_SATURATION_EN` undefined: the accumulator wraps modulo 2^`ACC_W`.
- `overflow_o` is produced in both builds.

## Test plan
- Single-lane sum: N_ROWS=1, beats 0x3F80 (1.0), 0x3F00 (0.5), 0x3E80 (0.25) with `last_i` on the third → `sum_o` = 0x0001C000 and `sum_valid_o` = 1 one cycle after the last beat.
- Strobes and special values: N_ROWS=4, strobe 0b1011, lanes {0x3F80, 0xBF80, 0x3F80, 0x0000} with `last_i` → `sum_o` = 0x00010000 (negative and masked lanes ignored).
- Back-pressure: `sum_ready_i` held 0 for 5 cycles → `ready_o` = 0 and `sum_o` stable throughout. After the handshake, the next vector starts from 0.
- Overflow: 2 beats of 0x4700 (32768.0) with `last_i` on the second → `overflow_o` = 1. `sum_o` = 0x00000000 without the macro, 0xFFFFFFFF with it.
- Clear mid-vector: 3 beats, then `clear_i` → accumulator 0, `busy_o` 0, state ACC. The next single beat 0x3F80 with `last_i` gives 0x00010000.
- Enable gating: `enable_i` = 0 with `valid_i` = 1 for 3 cycles → `ready_o` = 0 and the accumulator is unchanged.
